// File: rtl/maxpool_layer_scheduler_pkg.sv
// Shared types and helpers for the maxpool layer scheduler.
// Watchdog build option: MAXPOOL_SCHED_WDT_EN (undefined by default).
package maxpool_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_NEXT  = 3'd4
  } sched_state_t;

  localparam int CH_W   = 16;
  localparam int SIZE_W = 16;
  localparam int DESC_W = CH_W + SIZE_W + 1;

`ifdef MAXPOOL_SCHED_WDT_EN
  localparam bit SCHED_WDT_EN = 1'b1;
`else
  localparam bit SCHED_WDT_EN = 1'b0;
`endif

  typedef struct packed {
    logic              is_pool;
    logic [SIZE_W-1:0] img_size;
    logic [CH_W-1:0]   in_ch;
  } desc_t;

  // Output rows of a k=3/s=2/p=1 pool over all channels.
  function automatic logic [CH_W+SIZE_W-1:0] expected_rows(
    input logic [CH_W-1:0]   in_ch,
    input logic [SIZE_W-1:0] img_size
  );
    logic [CH_W+SIZE_W-1:0] half;
    half = (32'(img_size) + 32'd1) >> 1;
    return 32'(in_ch) * half;
  endfunction

endpackage

// File: rtl/maxpool_desc_table.sv
// Layer descriptor register file: one write port, one combinational read port.
module maxpool_desc_table
  import maxpool_layer_scheduler_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  desc_t            wr_data_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output desc_t            rd_data_o
);

  desc_t mem_q [DESC_DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DESC_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool_layer_scheduler.sv
// Walks a descriptor list, strobing layer codes into the spiking maxpool unit and checking beat counts.
// Optional watchdog: define MAXPOOL_SCHED_WDT_EN.
module maxpool_layer_scheduler
  import maxpool_layer_scheduler_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int IDX_W      = 2,
  parameter int BEAT_W     = 32,
  parameter int WDT_W      = 20
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_wr_addr,
  input  logic [CH_W-1:0]   cfg_in_ch,
  input  logic [SIZE_W-1:0] cfg_img_size,
  input  logic              cfg_is_pool,
  input  logic [IDX_W:0]    num_layers,
  input  logic              start,
  input  logic              abort,
  input  logic              ds_ready,
  output logic              code_valid,
  output logic [CH_W-1:0]   conv_in_ch,
  output logic [SIZE_W-1:0] conv_img_size,
  output logic              conv_or_maxpool,
  input  logic              Pooling_out_valid,
  output logic              Pooling_out_ready,
  input  logic              Pooling_out_done,
  output logic              busy,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              sched_done,
  output logic              err_beat,
  output logic              err_cfg,
  output logic              err_timeout
);

  localparam logic [IDX_W:0]    NL_MAX   = (IDX_W+1)'(DESC_DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    nl_q, nl_d;
  logic [BEAT_W-1:0] beat_q, beat_d, exp_q, exp_d;
  logic [BEAT_W-1:0] beat_inc, beat_now;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SIZE_W-1:0] sz_q, sz_d;
  logic              pool_q, pool_d;
  logic              err_beat_q, err_beat_d;
  logic              err_cfg_q, err_cfg_d;
  logic              err_to_q, err_to_d;
  desc_t             wr_desc, rd_desc;
  logic              tbl_we, ready, beat_acc, last_layer, wdt_hit;

  assign wr_desc = '{is_pool: cfg_is_pool, img_size: cfg_img_size, in_ch: cfg_in_ch};
  assign tbl_we  = cfg_wr_en && (state_q == S_IDLE);

  maxpool_desc_table #(
    .DESC_DEPTH (DESC_DEPTH),
    .IDX_W      (IDX_W)
  ) u_desc_table (
    .clk_i     (s_clk),
    .rst_n_i   (s_rst_n),
    .wr_en_i   (tbl_we),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (wr_desc),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_desc)
  );

  // Abort withdraws ready in the same cycle so no beat slips through on the way out.
  assign ready      = (state_q == S_RUN) && ds_ready && !abort;
  assign beat_acc   = Pooling_out_valid && ready;
  assign beat_inc   = (beat_q == BEAT_MAX) ? beat_q : beat_q + 1'b1;
  assign beat_now   = beat_acc ? beat_inc : beat_q;
  assign last_layer = ({1'b0, idx_q} == nl_q - 1'b1);

`ifdef MAXPOOL_SCHED_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;

  assign wdt_hit = (state_q == S_RUN) && (wdt_q == '1);

  // Backpressure freezes the count: a stalled consumer is not a hung producer.
  always_comb begin
    wdt_d = wdt_q;
    if (state_q != S_RUN || state_d != S_RUN || beat_acc) begin
      wdt_d = '0;
    end else if (ds_ready) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) wdt_q <= '0;
    else          wdt_q <= wdt_d;
  end
`else
  localparam int wdt_unused_w = WDT_W;
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nl_d       = nl_q;
    beat_d     = beat_q;
    exp_d      = exp_q;
    ch_d       = ch_q;
    sz_d       = sz_q;
    pool_d     = pool_q;
    err_beat_d = err_beat_q;
    err_cfg_d  = err_cfg_q;
    err_to_d   = err_to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_layers != '0 && num_layers <= NL_MAX) begin
            state_d    = S_FETCH;
            idx_d      = '0;
            nl_d       = num_layers;
            err_beat_d = 1'b0;
            err_cfg_d  = 1'b0;
            err_to_d   = 1'b0;
          end else if (num_layers == '0) begin
            err_cfg_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        exp_d = BEAT_W'(expected_rows(rd_desc.in_ch, rd_desc.img_size));
        if (!rd_desc.is_pool) begin
          state_d = S_NEXT;
        end else if (rd_desc.in_ch == '0 || rd_desc.img_size < SIZE_W'(3)) begin
          err_cfg_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          ch_d    = rd_desc.in_ch;
          sz_d    = rd_desc.img_size;
          pool_d  = rd_desc.is_pool;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RUN;
      S_RUN: begin
        beat_d = beat_now;
        if (Pooling_out_done) begin
          if (beat_now != exp_q) err_beat_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        beat_d = '0;
        if (last_layer) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && (abort || wdt_hit)) begin
      state_d    = S_IDLE;
      beat_d     = '0;
      ch_d       = ch_q;
      sz_d       = sz_q;
      pool_d     = pool_q;
      err_beat_d = err_beat_q;
      err_cfg_d  = err_cfg_q;
      if (wdt_hit) err_to_d = 1'b1;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      nl_q       <= '0;
      beat_q     <= '0;
      exp_q      <= '0;
      ch_q       <= '0;
      sz_q       <= '0;
      pool_q     <= 1'b0;
      err_beat_q <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nl_q       <= nl_d;
      beat_q     <= beat_d;
      exp_q      <= exp_d;
      ch_q       <= ch_d;
      sz_q       <= sz_d;
      pool_q     <= pool_d;
      err_beat_q <= err_beat_d;
      err_cfg_q  <= err_cfg_d;
      err_to_q   <= err_to_d;
    end
  end

  assign code_valid        = (state_q == S_ISSUE) && !abort;
  assign conv_in_ch        = ch_q;
  assign conv_img_size     = sz_q;
  assign conv_or_maxpool   = pool_q;
  assign Pooling_out_ready = ready;
  assign busy              = (state_q != S_IDLE);
  assign layer_idx         = idx_q;
  assign sched_done        = (state_q == S_NEXT) && last_layer && !abort;
  assign err_beat          = err_beat_q;
  assign err_cfg           = err_cfg_q;
  assign err_timeout       = SCHED_WDT_EN && err_to_q;

endmodule

// File: tb/tb_maxpool_layer_scheduler.sv
// Scoreboard bench for maxpool_layer_scheduler: a list-level model predicts code strobes and completion flags.
module tb_maxpool_layer_scheduler;

  localparam int DESC_DEPTH = 4;
  localparam int IDX_W      = 2;
  localparam int BEAT_W     = 32;
  localparam int WDT_W      = 8;

  logic              s_clk = 1'b0;
  logic              s_rst_n = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [IDX_W-1:0]  cfg_wr_addr = '0;
  logic [15:0]       cfg_in_ch = '0;
  logic [15:0]       cfg_img_size = '0;
  logic              cfg_is_pool = 1'b0;
  logic [IDX_W:0]    num_layers = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ds_ready = 1'b0;
  logic              code_valid;
  logic [15:0]       conv_in_ch;
  logic [15:0]       conv_img_size;
  logic              conv_or_maxpool;
  logic              Pooling_out_valid = 1'b0;
  logic              Pooling_out_ready;
  logic              Pooling_out_done = 1'b0;
  logic              busy;
  logic [IDX_W-1:0]  layer_idx;
  logic              sched_done;
  logic              err_beat;
  logic              err_cfg;
  logic              err_timeout;

  always #5 s_clk = ~s_clk;

  maxpool_layer_scheduler #(
    .DESC_DEPTH (DESC_DEPTH),
    .IDX_W      (IDX_W),
    .BEAT_W     (BEAT_W),
    .WDT_W      (WDT_W)
  ) dut (
    .s_clk             (s_clk),
    .s_rst_n           (s_rst_n),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_wr_addr       (cfg_wr_addr),
    .cfg_in_ch         (cfg_in_ch),
    .cfg_img_size      (cfg_img_size),
    .cfg_is_pool       (cfg_is_pool),
    .num_layers        (num_layers),
    .start             (start),
    .abort             (abort),
    .ds_ready          (ds_ready),
    .code_valid        (code_valid),
    .conv_in_ch        (conv_in_ch),
    .conv_img_size     (conv_img_size),
    .conv_or_maxpool   (conv_or_maxpool),
    .Pooling_out_valid (Pooling_out_valid),
    .Pooling_out_ready (Pooling_out_ready),
    .Pooling_out_done  (Pooling_out_done),
    .busy              (busy),
    .layer_idx         (layer_idx),
    .sched_done        (sched_done),
    .err_beat          (err_beat),
    .err_cfg           (err_cfg),
    .err_timeout       (err_timeout)
  );

  typedef struct {
    bit is_done;
    int ch;
    int sz;
    int idx;
    bit eb;
    bit ec;
  } ev_t;

  ev_t sbq[$];
  int  idx_log[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  sd_cnt  = 0;
  int  cv_cnt  = 0;
  bit  to_seen = 1'b0;

  int  m_ch   [DESC_DEPTH];
  int  m_sz   [DESC_DEPTH];
  bit  m_pool [DESC_DEPTH];
  int  delta  [DESC_DEPTH];

  bit  ws_en = 1'b0;
  int  ws_slot, ws_ch, ws_sz;
  bit  ws_pool;
  bit  bw_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  function automatic void push_code(input int ch, input int sz, input int idx);
    ev_t e;
    e.is_done = 1'b0; e.ch = ch; e.sz = sz; e.idx = idx; e.eb = 1'b0; e.ec = 1'b0;
    sbq.push_back(e);
  endfunction

  function automatic void push_done(input bit eb, input bit ec);
    ev_t e;
    e.is_done = 1'b1; e.ch = 0; e.sz = 0; e.idx = 0; e.eb = eb; e.ec = ec;
    sbq.push_back(e);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT emits a code strobe or a completion pulse.
  always @(negedge s_clk) begin
    if (s_rst_n) begin
      if (busy && (idx_log.size() == 0 || idx_log[$] != int'(layer_idx)))
        idx_log.push_back(int'(layer_idx));
      if (err_timeout) to_seen = 1'b1;
      if (code_valid) begin
        cv_cnt++;
        if (sbq.size() == 0) check("unexpected code_valid", 1, 0);
        else begin
          ev_t e;
          e = sbq.pop_front();
          check("code event order", e.is_done, 0);
          check("conv_in_ch", conv_in_ch, e.ch);
          check("conv_img_size", conv_img_size, e.sz);
          check("conv_or_maxpool", conv_or_maxpool, 1);
          check("layer_idx at code", layer_idx, e.idx);
        end
      end
      if (sched_done) begin
        sd_cnt++;
        if (sbq.size() == 0) check("unexpected sched_done", 1, 0);
        else begin
          ev_t e;
          e = sbq.pop_front();
          check("done event order", e.is_done, 1);
          check("err_beat at done", err_beat, e.eb);
          check("err_cfg at done", err_cfg, e.ec);
        end
      end
    end
  end

  task automatic write_desc(input int slot, input int ch, input int sz, input bit pool);
    cfg_wr_addr  = IDX_W'(slot);
    cfg_in_ch    = 16'(ch);
    cfg_img_size = 16'(sz);
    cfg_is_pool  = pool;
    cfg_wr_en    = 1'b1;
    tick();
    cfg_wr_en    = 1'b0;
    m_ch[slot] = ch; m_sz[slot] = sz; m_pool[slot] = pool;
  endtask

  // Plays the pool unit: delivers t handshaken beats, then the done pulse.
  task automatic drive_beats(input int t, input int mode, input bit comb);
    int sent = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit rdy_bad = 1'b0;
    while (sent < t && guard < 20000) begin
      guard++;
      if (comb && sent == t - 1) begin
        ds_ready = 1'b1; Pooling_out_valid = 1'b1; Pooling_out_done = 1'b1;
      end else begin
        Pooling_out_valid = ($urandom_range(0, 3) != 0);
        case (mode)
          0:       ds_ready = 1'b1;
          1:       begin ds_ready = tog; tog = !tog; end
          default: ds_ready = 1'($urandom_range(0, 1));
        endcase
      end
      @(negedge s_clk);
      if (Pooling_out_ready !== ds_ready) rdy_bad = 1'b1;
      if (Pooling_out_valid && Pooling_out_ready) sent++;
      tick();
      Pooling_out_done = 1'b0;
    end
    Pooling_out_valid = 1'b0;
    check("beats delivered within bound", sent, t);
    check("ready mirrors ds_ready", rdy_bad, 0);
    if (!(comb && t > 0)) begin
      Pooling_out_done = 1'b1;
      tick();
      Pooling_out_done = 1'b0;
    end
    ds_ready = 1'b0;
  endtask

  task automatic run_list(input int n, input int mode, input bit comb);
    bit vld [DESC_DEPTH];
    int beats [DESC_DEPTH];
    bit eb = 1'b0, ec = 1'b0;
    int nvalid = 0, skipped = 0, lat, w, sd0, cv0;
    bit first = 1'b1;
    if (ws_en) begin
      m_ch[ws_slot] = ws_ch; m_sz[ws_slot] = ws_sz; m_pool[ws_slot] = ws_pool;
    end
    for (int i = 0; i < n; i++) begin
      int expb;
      vld[i] = m_pool[i] && m_ch[i] != 0 && m_sz[i] >= 3;
      if (m_pool[i] && !vld[i]) ec = 1'b1;
      expb = m_ch[i] * ((m_sz[i] + 1) / 2);
      beats[i] = (expb + delta[i] < 0) ? 0 : expb + delta[i];
      if (vld[i]) begin
        nvalid++;
        push_code(m_ch[i], m_sz[i], i);
        if (beats[i] != expb) eb = 1'b1;
      end
    end
    push_done(eb, ec);
    idx_log.delete();
    sd0 = sd_cnt;
    cv0 = cv_cnt;
    num_layers = (IDX_W+1)'(n);
    start = 1'b1;
    if (ws_en) begin
      cfg_wr_addr = IDX_W'(ws_slot); cfg_in_ch = 16'(ws_ch);
      cfg_img_size = 16'(ws_sz); cfg_is_pool = ws_pool; cfg_wr_en = 1'b1;
    end
    tick();
    start = 1'b0;
    cfg_wr_en = 1'b0;
    ws_en = 1'b0;
    check("err_beat cleared by start", err_beat, 0);
    check("err_cfg cleared by start", err_cfg, 0);
    lat = 1;
    for (int i = 0; i < n; i++) begin
      if (!vld[i]) begin
        skipped++;
        continue;
      end
      while (!code_valid && lat < 200) begin
        tick();
        lat++;
      end
      check("code_valid latency", lat, (first ? 2 : 3) + 2 * skipped);
      first = 1'b0;
      skipped = 0;
      tick();
      if (bw_en) begin
        cfg_wr_addr = 1; cfg_in_ch = 16'd5; cfg_img_size = 16'd7; cfg_is_pool = 1'b1;
        cfg_wr_en = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
        bw_en = 1'b0;
      end
      drive_beats(beats[i], mode, comb);
      lat = 1;
    end
    w = 0;
    while (busy && w < 200) begin
      tick();
      w++;
    end
    check("returns to idle", busy, 0);
    check("sched_done pulses", sd_cnt - sd0, 1);
    check("code_valid pulses", cv_cnt - cv0, nvalid);
    check("layer_idx sequence length", idx_log.size(), n);
    for (int i = 0; i < n && i < idx_log.size(); i++) check("layer_idx sequence", idx_log[i], i);
  endtask

  initial begin
    int lat, sd0;
    for (int i = 0; i < DESC_DEPTH; i++) begin
      m_ch[i] = 0; m_sz[i] = 0; m_pool[i] = 1'b0; delta[i] = 0;
    end
    repeat (3) @(posedge s_clk);
    #1;
    ds_ready = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset code_valid", code_valid, 0);
    check("reset sched_done", sched_done, 0);
    check("reset ready", Pooling_out_ready, 0);
    check("reset err_beat", err_beat, 0);
    check("reset err_cfg", err_cfg, 0);
    check("reset err_timeout", err_timeout, 0);
    check("reset layer_idx", layer_idx, 0);
    check("reset conv_in_ch", conv_in_ch, 0);
    check("reset conv_img_size", conv_img_size, 0);
    check("reset conv_or_maxpool", conv_or_maxpool, 0);
    ds_ready = 1'b0;
    s_rst_n = 1'b1;
    tick();
    check("idle ready after reset", Pooling_out_ready, 0);

    // Cleared table: slot 0 is a skip layer.
    run_list(1, 0, 1'b0);

    // Single 64x32 layer, plus a write attempted while busy.
    write_desc(0, 64, 32, 1'b1);
    bw_en = 1'b1;
    run_list(1, 0, 1'b0);
    check("conv_in_ch holds", conv_in_ch, 64);
    check("conv_img_size holds", conv_img_size, 32);

    // One beat short; slot 1 must still read as empty.
    delta[0] = -1;
    run_list(2, 2, 1'b0);
    delta[0] = 0;
    repeat (3) tick();
    check("err_beat sticky", err_beat, 1);

    // Mixed list with skip and illegal layers, toggling ready, final beat with done.
    write_desc(0, 16, 8, 1'b1);
    write_desc(1, 0, 8, 1'b1);
    write_desc(2, 8, 4, 1'b0);
    write_desc(3, 4, 6, 1'b1);
    run_list(4, 1, 1'b1);

    // Illegal layer counts.
    num_layers = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("num_layers=0 stays idle", busy, 0);
    check("num_layers=0 err_cfg", err_cfg, 1);
    num_layers = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("num_layers>depth stays idle", busy, 0);

    // Write and start in the same cycle.
    ws_en = 1'b1; ws_slot = 0; ws_ch = 6; ws_sz = 5; ws_pool = 1'b1;
    run_list(1, 2, 1'b0);

    // Abort mid-run, then a clean run.
    write_desc(0, 8, 6, 1'b1);
    push_code(8, 6, 0);
    sd0 = sd_cnt;
    num_layers = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!code_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("abort run latency", lat, 2);
    tick();
    Pooling_out_valid = 1'b1; ds_ready = 1'b1;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort ready", Pooling_out_ready, 0);
    Pooling_out_valid = 1'b0;
    repeat (3) tick();
    ds_ready = 1'b0;
    check("abort no sched_done", sd_cnt - sd0, 0);
    write_desc(0, 4, 6, 1'b1);
    run_list(1, 0, 1'b0);

    // Randomised lists.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, DESC_DEPTH);
      for (int s = 0; s < DESC_DEPTH; s++) begin
        write_desc(s, $urandom_range(0, 8), $urandom_range(1, 12), ($urandom_range(0, 4) != 0));
        delta[s] = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 1) ? 1 : -1) : 0;
      end
      run_list(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int s = 0; s < DESC_DEPTH; s++) delta[s] = 0;

`ifdef MAXPOOL_SCHED_WDT_EN
    begin
      int w;
      write_desc(0, 8, 6, 1'b1);
      push_code(8, 6, 0);
      sd0 = sd_cnt;
      num_layers = 3'd1; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (!code_valid && lat < 200) begin
        tick();
        lat++;
      end
      tick();
      ds_ready = 1'b0;
      repeat (1000) tick();
      check("stall keeps running", busy, 1);
      check("stall no timeout", err_timeout, 0);
      ds_ready = 1'b1;
      w = 0;
      while (busy && w < 400) begin
        tick();
        w++;
      end
      ds_ready = 1'b0;
      check("watchdog forces idle", busy, 0);
      check("watchdog err_timeout", err_timeout, 1);
      check("watchdog no sched_done", sd_cnt - sd0, 0);
    end
`else
    check("err_timeout never set", to_seen, 0);
`endif

    repeat (3) tick();
    check("scoreboard drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
